alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: BITS_DATA, default 32, data width of operands, result and ALU ports.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  1  request present; req_ready  output  1  controller can accept.
REQ-005 Port: req_opcode  input  5  opcode from the shared opcode header; req_a, req_b  input  BITS_DATA  operands.
REQ-006 Port: alu_opcode  output  5, alu_a, alu_b  output  BITS_DATA  drive the shared combinational ALU.
REQ-007 Port: alu_result  input  BITS_DATA, alu_c, alu_s, alu_o, alu_z  input  1  ALU outputs, same cycle.
REQ-008 Port: rsp_valid  output  1, rsp_ready  input  1  response handshake.
REQ-009 Port: rsp_result  output  BITS_DATA, rsp_c, rsp_s, rsp_o, rsp_z, rsp_err  output  1  registered response.

Function
REQ-010 States SHALL be IDLE, EXEC, MUL_IT, DIV_IT, DONE; req_ready SHALL be 1 only in IDLE.
REQ-011 Acceptance SHALL occur on an edge with req_valid=1 and req_ready=1; opcode and operands latched then, later req changes ignored.
REQ-012 IDLE->EXEC for OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB; EXEC drives alu_opcode=latched opcode, alu_a/alu_b=latched operands, and captures alu_result and all four flags into rsp_* at the next edge, then DONE.
REQ-013 IDLE->MUL_IT for OP_MUL; IDLE->DIV_IT for OP_DIV/OP_MOD with b!=0.
REQ-014 MUL_IT: unsigned shift-add, exactly BITS_DATA cycles; each cycle alu_opcode=OP_ADD, alu_a=acc, alu_b=multiplicand; acc<=alu_result if multiplier[0]=1 else unchanged; multiplicand<<=1, multiplier>>=1.
REQ-015 MUL result SHALL be low BITS_DATA bits of the unsigned product; rsp_c=0, rsp_o=0, rsp_s=result MSB, rsp_z=(result==0).
REQ-016 DIV_IT: unsigned restoring division, exactly BITS_DATA cycles; each cycle shift {rem,dvd} left one bit, drive OP_SUB with alu_a=shifted rem low bits, alu_b=divisor.
REQ-017 Subtract SHALL succeed when bit shifted out of rem is 1 or alu_c=0 (no borrow): rem<=alu_result, quotient bit 1; otherwise rem kept, quotient bit 0; quotient shifts into dvd.
REQ-018 DIV returns quotient, MOD returns remainder; rsp_c=0, rsp_o=0, rsp_s=result MSB, rsp_z=(result==0), rsp_err=0.
REQ-019 DIV/MOD with b=0 SHALL skip iteration: IDLE->DONE capture with rsp_result=all ones (DIV) or a (MOD), rsp_o=1, rsp_err=1, rsp_c=0, rsp_s/rsp_z from result.
REQ-020 Any other opcode (incl. OP_NOP, OP_HLT) SHALL go IDLE->DONE with rsp_result=0, rsp_c=rsp_s=rsp_o=0, rsp_z=1, rsp_err=1.
REQ-021 Latency from acceptance edge to rsp_valid=1: 2 edges for EXEC ops, BITS_DATA+1 edges for MUL/DIV/MOD, 1 edge for REQ-019/REQ-020 cases.
REQ-022 rsp_valid=1 only in DONE; rsp_* SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-023 DONE->IDLE on edge with rsp_ready=1; no request accepted on that edge; rsp_valid=0 in IDLE.
REQ-024 Outside EXEC/MUL_IT/DIV_IT: alu_opcode=OP_NOP, alu_a=0, alu_b=0.
REQ-025 rsp_err=0 for all EXEC, MUL and non-zero-divisor DIV/MOD results.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, req_ready=1 after release, rsp_valid=0, rsp_result=0, all rsp flags 0, alu_opcode=OP_NOP, alu_a=alu_b=0, iteration counter 0.
REQ-027 Reset mid-operation SHALL abort it with no response produced; first edge after release may accept a request.

Verification
REQ-028 ADD 0x7FFFFFFF+0x00000001 -> rsp_result 0x80000000, S=1, O=1, C=0, Z=0, err=0, rsp_valid 2 edges after accept.
REQ-029 MUL 12345*678 -> rsp_result 8369910, Z=0, err=0, rsp_valid 33 edges after accept; MUL 0x10000*0x10000 -> 0, Z=1.
REQ-030 DIV 100/7 -> 14, MOD 100/7 -> 2; DIV 0xFFFFFFFF/0x80000000 -> 1, MOD -> 0x7FFFFFFF (shifted-out-bit path).
REQ-031 DIV 5/0 -> 0xFFFFFFFF, O=1, err=1; MOD 5/0 -> 5, err=1; both rsp_valid 1 edge after accept.
REQ-032 Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* unchanged, req_ready=0; raise rsp_ready -> rsp_valid=0 and req_ready=1 after that edge.
REQ-033 Assert rst_n=0 during DIV_IT iteration 10 -> all outputs at reset values immediately; after release SUB 5-5 -> rsp_result 0, Z=1, C=0.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// Bundle of request, response and shared-ALU signals around alu_seq_ctrl.
// The slave modport is the controller's view; the master modport is the
// surrounding system (requester, response consumer and the combinational ALU).
interface alu_seq_ctrl_if #(
    parameter int BITS_DATA = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [4:0]           req_opcode;
    logic [BITS_DATA-1:0] req_a;
    logic [BITS_DATA-1:0] req_b;

    logic [4:0]           alu_opcode;
    logic [BITS_DATA-1:0] alu_a;
    logic [BITS_DATA-1:0] alu_b;
    logic [BITS_DATA-1:0] alu_result;
    logic                 alu_c;
    logic                 alu_s;
    logic                 alu_o;
    logic                 alu_z;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [BITS_DATA-1:0] rsp_result;
    logic                 rsp_c;
    logic                 rsp_s;
    logic                 rsp_o;
    logic                 rsp_z;
    logic                 rsp_err;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b,
        input  alu_result, alu_c, alu_s, alu_o, alu_z,
        input  rsp_ready,
        output req_ready,
        output alu_opcode, alu_a, alu_b,
        output rsp_valid, rsp_result, rsp_c, rsp_s, rsp_o, rsp_z, rsp_err
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b,
        output alu_result, alu_c, alu_s, alu_o, alu_z,
        output rsp_ready,
        input  req_ready,
        input  alu_opcode, alu_a, alu_b,
        input  rsp_valid, rsp_result, rsp_c, rsp_s, rsp_o, rsp_z, rsp_err
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller in front of a shared combinational ALU.
// Single-step ops go straight through the ALU; MUL is an unsigned shift-add
// loop and DIV/MOD an unsigned restoring division loop, both reusing the ALU
// adder/subtractor once per cycle for BITS_DATA cycles.
module alu_seq_ctrl #(
    parameter int BITS_DATA = 32
) (
    input logic           clk,
    input logic           rst_n,
    alu_seq_ctrl_if.slave bus
);
    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_NOT = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_NEG = 5'd4;
    localparam logic [4:0] OP_ADD = 5'd5;
    localparam logic [4:0] OP_SUB = 5'd6;
    localparam logic [4:0] OP_MUL = 5'd7;
    localparam logic [4:0] OP_DIV = 5'd8;
    localparam logic [4:0] OP_MOD = 5'd9;

    localparam int CNT_W = (BITS_DATA > 1) ? $clog2(BITS_DATA) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BITS_DATA - 1);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL_IT,
        DIV_IT,
        DONE
    } state_t;

    state_t               state, state_nxt;

    // opa holds operand a / multiplicand / dividend-then-quotient,
    // opb holds operand b / multiplier / divisor, acc holds product / remainder
    logic [4:0]           op_q, op_nxt;
    logic [BITS_DATA-1:0] opa_q, opa_nxt;
    logic [BITS_DATA-1:0] opb_q, opb_nxt;
    logic [BITS_DATA-1:0] acc_q, acc_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;

    logic [4:0]           alu_op;
    logic [BITS_DATA-1:0] alu_a;
    logic [BITS_DATA-1:0] alu_b;

    logic                 load_rsp;
    logic                 flags_from_alu;
    logic [BITS_DATA-1:0] res_nxt;
    logic                 c_nxt, s_nxt, o_nxt, z_nxt, err_nxt;

    logic [BITS_DATA-1:0] rem_shift;
    logic                 sub_ok;

    logic [BITS_DATA-1:0] rsp_result_q;
    logic                 rsp_c_q, rsp_s_q, rsp_o_q, rsp_z_q, rsp_err_q;

    // Next state, ALU drive, iteration datapath and response capture values
    always_comb begin
        state_nxt      = state;
        op_nxt         = op_q;
        opa_nxt        = opa_q;
        opb_nxt        = opb_q;
        acc_nxt        = acc_q;
        cnt_nxt        = cnt_q;
        alu_op         = OP_NOP;
        alu_a          = '0;
        alu_b          = '0;
        load_rsp       = 1'b0;
        flags_from_alu = 1'b0;
        res_nxt        = '0;
        c_nxt          = 1'b0;
        s_nxt          = 1'b0;
        o_nxt          = 1'b0;
        z_nxt          = 1'b0;
        err_nxt        = 1'b0;
        rem_shift      = '0;
        sub_ok         = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    op_nxt  = bus.req_opcode;
                    opa_nxt = bus.req_a;
                    opb_nxt = bus.req_b;
                    acc_nxt = '0;
                    cnt_nxt = '0;
                    case (bus.req_opcode)
                        OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB: begin
                            state_nxt = EXEC;
                        end
                        OP_MUL: begin
                            state_nxt = MUL_IT;
                        end
                        OP_DIV, OP_MOD: begin
                            if (bus.req_b != '0) begin
                                state_nxt = DIV_IT;
                            end else begin
                                state_nxt = DONE;
                                load_rsp  = 1'b1;
                                res_nxt   = (bus.req_opcode == OP_DIV) ? '1 : bus.req_a;
                                o_nxt     = 1'b1;
                                err_nxt   = 1'b1;
                            end
                        end
                        default: begin
                            state_nxt = DONE;
                            load_rsp  = 1'b1;
                            err_nxt   = 1'b1;
                        end
                    endcase
                end
            end

            EXEC: begin
                alu_op         = op_q;
                alu_a          = opa_q;
                alu_b          = opb_q;
                load_rsp       = 1'b1;
                flags_from_alu = 1'b1;
                res_nxt        = bus.alu_result;
                c_nxt          = bus.alu_c;
                s_nxt          = bus.alu_s;
                o_nxt          = bus.alu_o;
                z_nxt          = bus.alu_z;
                state_nxt      = DONE;
            end

            MUL_IT: begin
                alu_op  = OP_ADD;
                alu_a   = acc_q;
                alu_b   = opa_q;
                acc_nxt = opb_q[0] ? bus.alu_result : acc_q;
                opa_nxt = opa_q << 1;
                opb_nxt = opb_q >> 1;
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_nxt = DONE;
                    load_rsp  = 1'b1;
                    res_nxt   = acc_nxt;
                end
            end

            DIV_IT: begin
                rem_shift = {acc_q[BITS_DATA-2:0], opa_q[BITS_DATA-1]};
                alu_op    = OP_SUB;
                alu_a     = rem_shift;
                alu_b     = opb_q;
                sub_ok    = acc_q[BITS_DATA-1] | ~bus.alu_c;
                acc_nxt   = sub_ok ? bus.alu_result : rem_shift;
                opa_nxt   = {opa_q[BITS_DATA-2:0], sub_ok};
                cnt_nxt   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_nxt = DONE;
                    load_rsp  = 1'b1;
                    res_nxt   = (op_q == OP_MOD) ? acc_nxt : opa_nxt;
                end
            end

            DONE: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (!flags_from_alu) begin
            s_nxt = res_nxt[BITS_DATA-1];
            z_nxt = (res_nxt == '0);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latched request and iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_NOP;
            opa_q <= '0;
            opb_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            op_q  <= op_nxt;
            opa_q <= opa_nxt;
            opb_q <= opb_nxt;
            acc_q <= acc_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Response registers, loaded only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_q <= '0;
            rsp_c_q      <= 1'b0;
            rsp_s_q      <= 1'b0;
            rsp_o_q      <= 1'b0;
            rsp_z_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else if (load_rsp) begin
            rsp_result_q <= res_nxt;
            rsp_c_q      <= c_nxt;
            rsp_s_q      <= s_nxt;
            rsp_o_q      <= o_nxt;
            rsp_z_q      <= z_nxt;
            rsp_err_q    <= err_nxt;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.rsp_valid  = (state == DONE);
    assign bus.alu_opcode = alu_op;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_c      = rsp_c_q;
    assign bus.rsp_s      = rsp_s_q;
    assign bus.rsp_o      = rsp_o_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: supplies the shared ALU, keeps a
// transaction-level model of the expected response and timing, and compares
// every falling edge plus a set of hand-computed directed results.
module tb_alu_seq_ctrl;
    localparam int W = 32;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_NOT = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_NEG = 5'd4;
    localparam logic [4:0] OP_ADD = 5'd5;
    localparam logic [4:0] OP_SUB = 5'd6;
    localparam logic [4:0] OP_MUL = 5'd7;
    localparam logic [4:0] OP_DIV = 5'd8;
    localparam logic [4:0] OP_MOD = 5'd9;
    localparam logic [4:0] OP_HLT = 5'd31;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         s;
        logic         o;
        logic         z;
    } alu_t;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         s;
        logic         o;
        logic         z;
        logic         err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.BITS_DATA(W)) bus ();

    alu_seq_ctrl #(.BITS_DATA(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference ALU behaviour: C is carry for ADD and borrow for SUB/NEG
    function automatic alu_t alu_eval(input logic [4:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        alu_t       t;
        logic [W:0] wide;
        t = '0;
        case (op)
            OP_NOT: t.r = ~a;
            OP_AND: t.r = a & b;
            OP_OR:  t.r = a | b;
            OP_NEG: begin
                t.r = '0 - a;
                t.c = (a != '0);
                t.o = (a == {1'b1, {(W-1){1'b0}}});
            end
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                t.r  = wide[W-1:0];
                t.c  = wide[W];
                t.o  = (a[W-1] == b[W-1]) && (t.r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                t.r = a - b;
                t.c = (a < b);
                t.o = (a[W-1] != b[W-1]) && (t.r[W-1] != a[W-1]);
            end
            default: t.r = '0;
        endcase
        t.s = t.r[W-1];
        t.z = (t.r == '0);
        return t;
    endfunction

    alu_t alu_out;
    assign alu_out        = alu_eval(bus.alu_opcode, bus.alu_a, bus.alu_b);
    assign bus.alu_result = alu_out.r;
    assign bus.alu_c      = alu_out.c;
    assign bus.alu_s      = alu_out.s;
    assign bus.alu_o      = alu_out.o;
    assign bus.alu_z      = alu_out.z;

    function automatic logic is_exec(input logic [4:0] op);
        return (op == OP_NOT) || (op == OP_AND) || (op == OP_OR) ||
               (op == OP_NEG) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic rsp_t exp_rsp(input logic [4:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        rsp_t         e;
        alu_t         t;
        logic [2*W-1:0] prod;
        e = '0;
        if (is_exec(op)) begin
            t = alu_eval(op, a, b);
            e.r = t.r;
            e.c = t.c;
            e.s = t.s;
            e.o = t.o;
            e.z = t.z;
        end else begin
            if (op == OP_MUL) begin
                prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.r  = prod[W-1:0];
            end else if (op == OP_DIV || op == OP_MOD) begin
                if (b != '0) begin
                    e.r = (op == OP_DIV) ? a / b : a % b;
                end else begin
                    e.r   = (op == OP_DIV) ? '1 : a;
                    e.o   = 1'b1;
                    e.err = 1'b1;
                end
            end else begin
                e.r   = '0;
                e.err = 1'b1;
            end
            e.s = e.r[W-1];
            e.z = (e.r == '0);
        end
        return e;
    endfunction

    function automatic int exp_lat(input logic [4:0] op, input logic [W-1:0] b);
        if (is_exec(op)) return 2;
        if (op == OP_MUL) return W + 1;
        if ((op == OP_DIV || op == OP_MOD) && b != '0) return W + 1;
        return 1;
    endfunction

    function automatic logic [4:0] busy_alu_op(input logic [4:0] op);
        if (op == OP_MUL) return OP_ADD;
        if (op == OP_DIV || op == OP_MOD) return OP_SUB;
        return op;
    endfunction

    // Transaction model: phase 0 waiting, 1 computing, 2 response offered
    int           m_phase = 0;
    int           m_left = 0;
    logic [4:0]   m_op = OP_NOP;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    rsp_t         m_exp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
        end else begin
            case (m_phase)
                0: if (bus.req_valid) begin
                    m_op    <= bus.req_opcode;
                    m_a     <= bus.req_a;
                    m_b     <= bus.req_b;
                    m_exp   <= exp_rsp(bus.req_opcode, bus.req_a, bus.req_b);
                    m_left  <= exp_lat(bus.req_opcode, bus.req_b) - 1;
                    m_phase <= (exp_lat(bus.req_opcode, bus.req_b) == 1) ? 2 : 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end
                default: if (bus.rsp_ready) m_phase <= 0;
            endcase
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        if (!rst_n) begin
            cmp("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            cmp("rst_rsp_bundle", 64'({bus.rsp_result, bus.rsp_c, bus.rsp_s, bus.rsp_o,
                                       bus.rsp_z, bus.rsp_err}), 64'd0);
            cmp("rst_alu_op", 64'(bus.alu_opcode), 64'(OP_NOP));
            cmp("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
        end else begin
            cmp("req_ready", 64'(bus.req_ready), 64'(m_phase == 0));
            cmp("rsp_valid", 64'(bus.rsp_valid), 64'(m_phase == 2));
            if (m_phase == 2) begin
                cmp("rsp_bundle", 64'({bus.rsp_result, bus.rsp_c, bus.rsp_s, bus.rsp_o,
                                      bus.rsp_z, bus.rsp_err}), 64'(m_exp));
            end
            if (m_phase == 1) begin
                cmp("alu_busy_op", 64'(bus.alu_opcode), 64'(busy_alu_op(m_op)));
                if (is_exec(m_op)) begin
                    cmp("alu_exec_ab", {bus.alu_a, bus.alu_b}, {m_a, m_b});
                end
            end else begin
                cmp("alu_idle_op", 64'(bus.alu_opcode), 64'(OP_NOP));
                cmp("alu_idle_ab", {bus.alu_a, bus.alu_b}, 64'd0);
            end
        end
    endtask

    // Continuous comparison against the model on every falling edge
    always @(negedge clk) checkOutput();

    task automatic applyStimulus(input logic [4:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int hold,
                                 output rsp_t got, output int lat);
        @(negedge clk);
        #1;
        cmp("accept_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.rsp_ready  = 1'b0;
        @(posedge clk);
        #1;
        lat = 1;
        bus.req_valid  = 1'b0;
        bus.req_opcode = 5'($urandom);
        bus.req_a      = $urandom;
        bus.req_b      = $urandom;
        while (!bus.rsp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = {bus.rsp_result, bus.rsp_c, bus.rsp_s, bus.rsp_o, bus.rsp_z, bus.rsp_err};
        if (!bus.rsp_valid) begin
            cmp("rsp_timeout", 64'd0, 64'd1);
            return;
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        cmp("hold_stable", 64'({bus.rsp_result, bus.rsp_c, bus.rsp_s, bus.rsp_o,
                               bus.rsp_z, bus.rsp_err}), 64'(got));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        cmp("post_release", 64'({bus.rsp_valid, bus.req_ready}), 64'b01);
    endtask

    task automatic directed(input string name, input logic [4:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int hold, input logic [W-1:0] exp_r,
                            input logic [4:0] exp_flags, input int exp_latency);
        rsp_t got;
        int   lat;
        applyStimulus(op, a, b, hold, got, lat);
        cmp({name, "_result"}, 64'(got.r), 64'(exp_r));
        cmp({name, "_flags"}, 64'({got.c, got.s, got.o, got.z, got.err}), 64'(exp_flags));
        cmp({name, "_latency"}, 64'(lat), 64'(exp_latency));
    endtask

    function automatic logic [4:0] pick_op(input int sel);
        case (sel)
            0: return OP_NOP;
            1: return OP_NOT;
            2: return OP_AND;
            3: return OP_OR;
            4: return OP_NEG;
            5: return OP_ADD;
            6: return OP_SUB;
            7: return OP_MUL;
            8: return OP_DIV;
            9: return OP_MOD;
            10: return OP_HLT;
            default: return 5'($urandom);
        endcase
    endfunction

    // Abort a division partway through its iterations with an async reset
    task automatic resetDuringDiv();
        @(negedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.req_opcode = OP_DIV;
        bus.req_a      = $urandom;
        bus.req_b      = $urandom_range(1, 1000);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        cmp("abort_req_ready", 64'(bus.req_ready), 64'd1);
        cmp("abort_alu_op", 64'(bus.alu_opcode), 64'(OP_NOP));
        cmp("abort_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
        cmp("abort_rsp_bundle", 64'({bus.rsp_result, bus.rsp_c, bus.rsp_s, bus.rsp_o,
                                    bus.rsp_z, bus.rsp_err}), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rsp_t         got;
        int           lat;
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        bus.req_valid  = 1'b0;
        bus.req_opcode = OP_NOP;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b0;
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        directed("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 5'b01100, 2);
        directed("mul", OP_MUL, 32'd12345, 32'd678, 0, 32'd8369910, 5'b00000, 33);
        directed("mul_wrap", OP_MUL, 32'h10000, 32'h10000, 1, 32'h0, 5'b00010, 33);
        directed("div", OP_DIV, 32'd100, 32'd7, 0, 32'd14, 5'b00000, 33);
        directed("mod", OP_MOD, 32'd100, 32'd7, 2, 32'd2, 5'b00000, 33);
        directed("div_big", OP_DIV, 32'hFFFFFFFF, 32'h80000000, 0, 32'h1, 5'b00000, 33);
        directed("mod_big", OP_MOD, 32'hFFFFFFFF, 32'h80000000, 0, 32'h7FFFFFFF, 5'b00000, 33);
        directed("div0", OP_DIV, 32'd5, 32'd0, 0, 32'hFFFFFFFF, 5'b01101, 1);
        directed("mod0", OP_MOD, 32'd5, 32'd0, 0, 32'd5, 5'b00101, 1);
        directed("hold5", OP_AND, 32'hF0F0, 32'h0FF0, 5, 32'h00F0, 5'b00000, 2);
        directed("nop", OP_NOP, 32'd3, 32'd4, 0, 32'h0, 5'b00011, 1);
        directed("hlt", OP_HLT, 32'd3, 32'd4, 1, 32'h0, 5'b00011, 1);

        resetDuringDiv();
        directed("sub_after_rst", OP_SUB, 32'd5, 32'd5, 0, 32'h0, 5'b00010, 2);

        for (int i = 0; i < 40; i++) begin
            op = pick_op($urandom_range(0, 11));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            applyStimulus(op, a, b, $urandom_range(0, 3), got, lat);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop if the run ever stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
